// File: rtl/invader_formation.sv
// Row of NUM_INV invaders marching side to side with per-invader hit points,
// one-hit-per-projectile lock, saturating score, wave respawn and landing.
module invader_formation #(
   parameter int NUM_INV   = 5,
   parameter int SPACING   = 40,
   parameter int HP_W      = 2,
   parameter int HP_INIT   = 3,
   parameter int X_MIN     = 96,
   parameter int X_MAX     = 389,
   parameter int START_X   = 100,
   parameter int START_Y   = 10,
   parameter int DROP      = 5,
   parameter int Y_LIMIT   = 440,
   parameter int HALF_W    = 10,
   parameter int HEIGHT    = 20,
   parameter int PROJ_HALF = 5,
   parameter int SCORE_PTS = 50
) (
   input  logic                     dclk,
   input  logic                     clr,
   input  logic                     play,
   input  logic                     move_tick,
   input  logic                     proj_valid,
   input  logic [9:0]               proj_x,
   input  logic [9:0]               proj_y,
   output logic [9:0]               enemy_x,
   output logic [9:0]               enemy_y,
   output logic [NUM_INV-1:0]       alive,
   output logic [NUM_INV*HP_W-1:0]  hp,
   output logic                     proj_consume,
   output logic                     kill_pulse,
   output logic [13:0]              score,
   output logic [3:0]               wave,
   output logic                     landed
);

   typedef enum logic [1:0] {
      IDLE,
      MARCH,
      RESPAWN,
      LANDED
   } state_e;

   localparam logic [HP_W-1:0]         HP_SPAWN  = HP_W'(HP_INIT);
   localparam logic [NUM_INV*HP_W-1:0] HP_ALL    = {NUM_INV{HP_SPAWN}};
   localparam logic [14:0]             SCORE_MAX = 15'd16383;

   state_e                    state_q, state_d;
   logic [9:0]                x_q, x_d;
   logic [9:0]                y_q, y_d;
   logic                      dir_q, dir_d;
   logic [NUM_INV-1:0]        alive_q, alive_d;
   logic [NUM_INV*HP_W-1:0]   hp_q, hp_d;
   logic                      cons_q, cons_d;
   logic                      kill_q, kill_d;
   logic                      lock_q, lock_d;
   logic                      landed_q, landed_d;
   logic [13:0]               score_q, score_d;
   logic [3:0]                wave_q, wave_d;

   logic [10:0]               px, py, ex, ey;
   logic [10:0]               cx [NUM_INV];
   logic                      in_y;
   logic [NUM_INV-1:0]        overlap;
   logic [NUM_INV-1:0]        hit_oh;
   logic                      any_hit;

   logic [NUM_INV-1:0]        alive_h;
   logic [NUM_INV*HP_W-1:0]   hp_h;
   logic [HP_W-1:0]           hp_i;
   logic                      kill_h;
   logic [14:0]               score_sum;
   logic [13:0]               score_h;

   logic                      at_edge;
   logic [10:0]               y_drop;
   logic                      moving;
   logic                      land;

   assign px = {1'b0, proj_x};
   assign py = {1'b0, proj_y};
   assign ex = {1'b0, x_q};
   assign ey = {1'b0, y_q};

   // Left edge is compared as px+PROJ_HALF+HALF_W > cx to stay unsigned.
   always_comb begin
      in_y = (py > ey) && (py < ey + 11'(HEIGHT));
      for (int i = 0; i < NUM_INV; i++) begin
         cx[i] = ex + 11'(i * SPACING);
         overlap[i] = proj_valid && alive_q[i] && !lock_q && in_y
            && (px + 11'(PROJ_HALF + HALF_W) > cx[i])
            && (px < cx[i] + 11'(HALF_W + PROJ_HALF));
      end
   end

   assign hit_oh  = overlap & (~overlap + NUM_INV'(1));
   assign any_hit = |overlap;

   always_comb begin
      alive_h = alive_q;
      hp_h    = hp_q;
      kill_h  = 1'b0;
      hp_i    = '0;
      for (int i = 0; i < NUM_INV; i++) begin
         hp_i = hp_q[i*HP_W +: HP_W];
         if (hit_oh[i]) begin
            if (hp_i > HP_W'(1)) begin
               hp_h[i*HP_W +: HP_W] = hp_i - HP_W'(1);
            end else begin
               hp_h[i*HP_W +: HP_W] = '0;
               alive_h[i] = 1'b0;
               kill_h     = 1'b1;
            end
         end
      end
   end

   assign score_sum = {1'b0, score_q} + 15'(SCORE_PTS);
   assign score_h   = !kill_h ? score_q :
                      (score_sum > SCORE_MAX) ? SCORE_MAX[13:0] :
                      score_sum[13:0];

   assign at_edge = dir_q ? (x_q <= 10'(X_MIN)) : (x_q >= 10'(X_MAX));
   assign y_drop  = ey + 11'(DROP);
   assign moving  = (state_q == MARCH) && move_tick;
   assign land    = moving && at_edge && (y_drop >= 11'(Y_LIMIT));

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      dir_d    = dir_q;
      alive_d  = alive_q;
      hp_d     = hp_q;
      cons_d   = 1'b0;
      kill_d   = 1'b0;
      lock_d   = proj_valid ? lock_q : 1'b0;
      landed_d = landed_q;
      score_d  = score_q;
      wave_d   = wave_q;
      if (!play) begin
         state_d  = IDLE;
         x_d      = 10'(START_X);
         y_d      = 10'(START_Y);
         dir_d    = 1'b0;
         alive_d  = '1;
         hp_d     = HP_ALL;
         lock_d   = 1'b0;
         landed_d = 1'b0;
         score_d  = '0;
         wave_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = MARCH;
            MARCH: begin
               if (moving) begin
                  if (at_edge) begin
                     dir_d = ~dir_q;
                     y_d   = y_drop[9:0];
                  end else if (dir_q) begin
                     x_d = x_q - 10'd1;
                  end else begin
                     x_d = x_q + 10'd1;
                  end
               end
               if (any_hit) begin
                  cons_d = 1'b1;
                  lock_d = 1'b1;
               end
               alive_d = alive_h;
               hp_d    = hp_h;
               kill_d  = kill_h;
               score_d = score_h;
               // Clearing the wave outranks a simultaneous landing drop.
               if (alive_h == '0) begin
                  state_d = RESPAWN;
               end else if (land) begin
                  state_d  = LANDED;
                  landed_d = 1'b1;
               end
            end
            RESPAWN: begin
               state_d = MARCH;
               x_d     = 10'(START_X);
               y_d     = 10'(START_Y);
               dir_d   = 1'b0;
               alive_d = '1;
               hp_d    = HP_ALL;
               wave_d  = wave_q + 4'd1;
            end
            LANDED: state_d = LANDED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge dclk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         x_q      <= 10'(START_X);
         y_q      <= 10'(START_Y);
         dir_q    <= 1'b0;
         alive_q  <= '1;
         hp_q     <= HP_ALL;
         cons_q   <= 1'b0;
         kill_q   <= 1'b0;
         lock_q   <= 1'b0;
         landed_q <= 1'b0;
         score_q  <= '0;
         wave_q   <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dir_q    <= dir_d;
         alive_q  <= alive_d;
         hp_q     <= hp_d;
         cons_q   <= cons_d;
         kill_q   <= kill_d;
         lock_q   <= lock_d;
         landed_q <= landed_d;
         score_q  <= score_d;
         wave_q   <= wave_d;
      end
   end

   assign enemy_x      = x_q;
   assign enemy_y      = y_q;
   assign alive        = alive_q;
   assign hp           = hp_q;
   assign proj_consume = cons_q;
   assign kill_pulse   = kill_q;
   assign score        = score_q;
   assign wave         = wave_q;
   assign landed       = landed_q;

endmodule

// File: doc/invader_formation.md
Name: invader_formation

Overview:
- Parametrised successor to the single-row invader enemy: a row of NUM_INV invaders marching side to side, dropping at each edge.
- Per-invader hit points, a one-hit-per-projectile lock, saturating score, wave respawn and landed (game-over) detection.
- Sits between the projectile block (proj_x/proj_y/proj_valid) and the VGA renderer/score display (enemy_x, enemy_y, alive, hp, score).

Parameters:
NUM_INV, 5, invaders in the row; invader i is centred at enemy_x + i*SPACING
SPACING, 40, horizontal pitch between invader centres (pixels)
HP_W, 2, hit-point field width per invader
HP_INIT, 3, hit points at spawn (1..2^HP_W-1)
X_MIN, 96, leftmost allowed anchor enemy_x
X_MAX, 389, rightmost allowed anchor enemy_x
START_X, 100, anchor x at spawn
START_Y, 10, anchor y at spawn
DROP, 5, y increment at each edge reversal
Y_LIMIT, 440, enemy_y at or beyond this value means landed
HALF_W, 10, invader half width
HEIGHT, 20, invader hitbox height below enemy_y
PROJ_HALF, 5, projectile half width
SCORE_PTS, 50, points per kill

Ports:
dclk  in  1  system clock; all state on rising edge
clr  in  1  asynchronous, active-low reset
play  in  1  1 = game running; 0 = hold formation in spawn state
move_tick  in  1  one-cycle movement enable from the game-speed divider
proj_valid  in  1  projectile on screen
proj_x  in  10  projectile centre x
proj_y  in  10  projectile y
enemy_x  out  10  anchor x (centre of invader 0)
enemy_y  out  10  anchor y (top edge)
alive  out  NUM_INV  bit i = invader i alive
hp  out  NUM_INV*HP_W  hp[i*HP_W +: HP_W] = remaining hits of invader i
proj_consume  out  1  one-cycle pulse: projectile hit something; projectile block must remove it
kill_pulse  out  1  one-cycle pulse: an invader died this hit
score  out  14  accumulated score, saturates at 16383
wave  out  4  waves cleared, wraps 15 -> 0
landed  out  1  formation reached Y_LIMIT; held until restart

Behaviour:
- Reset (clr=0, async) and play=0 (sync): enemy_x=START_X, enemy_y=START_Y, direction=right, alive=all 1, every hp=HP_INIT, score=0, wave=0, landed=0, proj_consume=0, kill_pulse=0, hit_lock=0, state=IDLE.
- States: IDLE -> MARCH when play=1. MARCH -> LANDED on a drop that makes enemy_y >= Y_LIMIT. MARCH -> RESPAWN when alive becomes all 0. RESPAWN -> MARCH after one cycle. LANDED holds until play=0. play=0 forces IDLE from any state.
- Movement (MARCH, move_tick=1 only):
  - direction right and enemy_x < X_MAX: enemy_x+1. Left and enemy_x > X_MIN: enemy_x-1.
  - At the edge: x unchanged, direction toggles, enemy_y += DROP.
  - Anchor never leaves [X_MIN, X_MAX].
- RESPAWN: position, direction, alive and hp reload their spawn values; wave += 1; score kept.
- Collision (MARCH only), evaluated against pre-update position, all arithmetic 11-bit unsigned, no underflow:
  - Invader i is hit when proj_valid & alive[i] & !hit_lock & proj_y > enemy_y & proj_y < enemy_y+HEIGHT & proj_x+PROJ_HALF > cx_i-HALF_W & proj_x < cx_i+HALF_W+PROJ_HALF, where cx_i = enemy_x + i*SPACING.
  - When several invaders qualify, the lowest index is hit; one hit per cycle.
- Hit effect, registered with 1-cycle latency (outputs change on the edge after the overlapping inputs):
  - proj_consume=1 and hit_lock=1.
  - hp_i > 1: hp_i - 1.
  - hp_i == 1: hp_i=0, alive[i]=0, kill_pulse=1, score=min(score+SCORE_PTS, 16383).
- hit_lock clears on the first cycle with proj_valid=0. A lingering projectile can therefore hit only once.
- Simultaneous events:
  - Hit plus move_tick in the same cycle: both apply.
  - Last kill plus a landing drop in the same cycle: RESPAWN wins and landed stays 0.
  - play=0 in the same cycle as a hit: the reset values win.
- Dead invaders never collide. Invaders positioned beyond x=639 are not clipped here; the renderer clips them.

Test Plan:
- Reset/idle: clr=0, then release with play=0 for 10 cycles -> enemy_x=100, enemy_y=10, alive=5'b11111, each hp=3, score=0, no pulses.
- March/reverse: play=1, 289 move_ticks -> enemy_x=389. Next tick -> x=389, y=15, direction left. Next tick -> x=388.
- Multi-hit kill with lock: anchor (100,10). Projectile (140,20) valid for 5 cycles -> one proj_consume, hp[1]=2. Drop valid, re-assert twice with a valid gap between -> hp[1]=0, alive[1]=0, kill_pulse once, score=50.
- Lowest index wins: SPACING=15 at the same anchor, projectile (108,20) overlapping invaders 0 and 1 -> only hp[0] decrements.
- Wave clear: kill all 5 invaders (15 hits) -> score=250, a RESPAWN cycle, then wave=1, alive=all 1, x=100, y=10. Repeat until score reaches 16383 -> saturates.
- Landed and restart: Y_LIMIT=20, two edge drops -> landed=1, movement frozen. play=0 one cycle -> landed=0, score=0, spawn position restored.
